// File: rtl/seven_seg_scan_if.sv
// Display bus for seven_seg_scan: CPU-side value/control inputs and board-side segment/anode pins.
// The blink request lines exist only when SEVEN_SEG_BLINK_EN is defined.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp;
  logic                lz_blank;
  logic                enable;
`ifdef SEVEN_SEG_BLINK_EN
  logic [DIGITS-1:0]   blink;
`endif
  logic [6:0]          seg;
  logic                seg_dp;
  logic [DIGITS-1:0]   an;

  modport master (
    output value, load, dp, lz_blank, enable,
`ifdef SEVEN_SEG_BLINK_EN
    output blink,
`endif
    input  seg, seg_dp, an
  );

  modport slave (
    input  value, load, dp, lz_blank, enable,
`ifdef SEVEN_SEG_BLINK_EN
    input  blink,
`endif
    output seg, seg_dp, an
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment scanner with shadow registers, leading-zero blanking and a dead cycle per slot.
// Optional per-digit blinking is compiled in with SEVEN_SEG_BLINK_EN.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLINK_DIV      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
    $error("seven_seg_scan: parameter out of range");
  end

  typedef enum logic {DEAD, SHOW} state_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Bit k set when nibbles DIGITS-1..k are all zero; digit 0 is never blanked.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] m;
    logic              zrun;
    m    = '0;
    zrun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zrun = zrun & (v[4*k +: 4] == 4'h0);
      m[k] = zrun;
    end
    return m;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                first_q, first_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpsh_q, dpsh_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
`ifdef SEVEN_SEG_BLINK_EN
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_DIV - 1);
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                phase_q, phase_d;
`endif

  logic                tick;
  logic [DIGITS-1:0]   lzm;
  logic [DIGITS-1:0]   sel;
  logic [6:0]          lit;
  logic                dot;

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    val_d    = bus.load ? bus.value : val_q;
    dpsh_d   = bus.load ? bus.dp : dpsh_q;
    first_d  = first_q & ~tick;

    // The very first tick opens slot 0 instead of advancing past it.
    idx_d = idx_q;
    if (tick && !first_q) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    state_d = state_q;
    if (tick) begin
      state_d = DEAD;
    end else if (state_q == DEAD) begin
      state_d = SHOW;
    end

`ifdef SEVEN_SEG_BLINK_EN
    frm_d   = frm_q;
    phase_d = phase_q;
    if (tick && !first_q && (idx_q == IDX_MAX)) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
`endif

    lzm = lz_mask(val_q);
    lit = 7'h00;
    dot = 1'b0;
    sel = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        lit = (bus.lz_blank && lzm[k]) ? 7'h00 : seg_enc(val_q[4*k +: 4]);
        dot = dpsh_q[k];
        sel[k] = (state_d == SHOW) && !first_d && bus.enable;
`ifdef SEVEN_SEG_BLINK_EN
        if (phase_d && bus.blink[k]) begin
          sel[k] = 1'b0;
        end
`endif
      end
    end
    if (first_d) begin
      lit = 7'h00;
      dot = 1'b0;
    end

    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    seg_dp_d = (SEG_ACTIVE_LOW != 0) ? ~dot : dot;
    an_d     = (AN_ACTIVE_LOW != 0) ? ~sel : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEAD;
      cnt_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      val_q    <= '0;
      dpsh_q   <= '0;
      seg_q    <= (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      seg_dp_q <= (SEG_ACTIVE_LOW != 0);
      an_q     <= (AN_ACTIVE_LOW != 0) ? '1 : '0;
`ifdef SEVEN_SEG_BLINK_EN
      frm_q    <= '0;
      phase_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      val_q    <= val_d;
      dpsh_q   <= dpsh_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
`ifdef SEVEN_SEG_BLINK_EN
      frm_q    <= frm_d;
      phase_q  <= phase_d;
`endif
    end
  end

  assign bus.seg    = seg_q;
  assign bus.seg_dp = seg_dp_q;
  assign bus.an     = an_q;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed driver for a parametrised bank of common-anode/cathode 7-segment digits. Captures a packed hex value into a shadow register on a load strobe and scans one digit at a time at a programmable rate. Supports per-digit decimal points, leading-zero suppression, global enable and a dead cycle between digits to suppress ghosting. Sits between the CPU output register and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1 = seg/seg_dp pins driven low to light
AN_ACTIVE_LOW, 1, 1 = an pins driven low to select a digit
BLINK_DIV, 64, full scan frames per blink half-period (used only with SEVEN_SEG_BLINK_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*DIGITS  packed nibbles; digit 0 = value[3:0] (rightmost)
load  in  1  1-cycle strobe; captures value and dp into shadow registers
dp  in  DIGITS  decimal point per digit
lz_blank  in  1  1 = suppress leading zeros
enable  in  1  0 = all anodes inactive
blink  in  DIGITS  per-digit blink request (present only with SEVEN_SEG_BLINK_EN)
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a
seg_dp  out  1  decimal point segment
an  out  DIGITS  digit selects, one-hot when active

Behaviour:
- Reset (rst_n low, async): shadow value/dp = 0, prescaler = 0, digit index = 0, an all inactive, seg and seg_dp inactive (all off at pin polarity). Release is synchronous to clk in effect; first tick after SCAN_DIV cycles.
- Shadow: on load, value/dp captured at the clock edge; display uses shadow only; load mid-slot changes the currently shown digit's pattern on the next clock.
- Prescaler: counts 0..SCAN_DIV-1, wraps; tick = (count == SCAN_DIV-1).
- Digit index: advances on tick; DIGITS-1 wraps to 0. Frame = DIGITS slots.
- Slot FSM, 2 states: DEAD (1 clk after tick: an inactive, seg/seg_dp loaded with new digit's pattern) -> SHOW (remaining SCAN_DIV-1 clks: an one-hot on index). All outputs registered.
- Encoding (logical, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero suppression: with lz_blank=1, digit k blanked (seg=0, seg_dp still per dp) iff shadow nibbles DIGITS-1..k are all 0 and k != 0; digit 0 always displayed.
- enable=0: an inactive next clock; prescaler and index keep running so re-enable resumes in phase.
- Polarity: SEG_ACTIVE_LOW inverts seg and seg_dp; AN_ACTIVE_LOW inverts an; applied at the output registers.
- DIGITS=1: index constant 0, DEAD cycle still inserted every tick.

Optional Feature:
SEVEN_SEG_BLINK_EN: adds blink port and a frame counter toggling a blink phase every BLINK_DIV completed frames (frame complete = tick with index DIGITS-1). When phase is off, digits with blink[k]=1 have an held inactive for their slot; other digits unaffected. Phase and counter reset to 0 (phase on). Without macro: no blink port, no frame counter, no blinking logic.

Test Plan:
- Reset: DIGITS=4, SCAN_DIV=4, both polarities active-low; hold rst_n low -> an=4'b1111, seg=7'h7F, seg_dp=1; release -> first an=4'b1110 after DEAD cycle following first tick.
- Scan order: load value=16'h12AF, dp=0 -> per slot an 1110/1101/1011/0111 with seg = ~71, ~77, ~5B, ~06; one DEAD cycle (an=1111) between each.
- Leading zeros: value=16'h0005, lz_blank=1 -> digits 3,2,1 seg=7'h7F, digit 0 seg=~6D; value=16'h0000 -> only digit 0 lit showing ~3F.
- Mid-slot load: during digit 0 SHOW, load value=16'h0008 -> seg changes to ~7F on the clock after load, an unchanged.
- Enable/async reset: enable=0 for 10 clks -> an=1111, index keeps advancing; assert rst_n low mid-SHOW -> outputs off immediately, without waiting for clk.
- Blink (macro on, BLINK_DIV=2): blink=4'b0001 -> digit 0 an stays inactive for frames 2-3, lit for frames 0-1 and 4-5; other digits lit every frame.
